// File: rtl/mem_arbiter_if.sv
// Bundle of signals shared by the arbiter, the two requesters and the memory port.
// slave is the arbiter's view; master is the requester/memory side (testbench).
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  // Data requester (lda/str)
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  // Memory port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // Status
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single fixed-latency synchronous memory port.
// Data accesses win, except that fetch is forced through after MAX_WAIT
// consecutive losses. One access is in flight at a time:
// IDLE -> ACCESS -> (WAIT x MEM_LAT-1) -> RESP -> IDLE.
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int SW       = $clog2(MAX_WAIT + 1);
  localparam int LAT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam int LAT_LOAD = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t            state_reg;
  logic              owner_reg;      // 1 = data path owns the access, 0 = fetch
  logic [SW-1:0]     starve_cnt_reg;
  logic [LAT_W-1:0]  lat_cnt_reg;
  logic              if_gnt_reg;
  logic              d_gnt_reg;
  logic              if_valid_reg;
  logic              d_valid_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              busy_reg;
  logic              pick_fetch;

  // Fetch wins when data is absent, or when fetch has already lost MAX_WAIT times in a row.
  assign pick_fetch = bus.if_req && (!bus.d_req || (starve_cnt_reg == SW'(MAX_WAIT)));

  // Arbitration FSM with registered handshake and memory-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      starve_cnt_reg <= '0;
      lat_cnt_reg    <= '0;
      if_gnt_reg     <= 1'b0;
      d_gnt_reg      <= 1'b0;
      if_valid_reg   <= 1'b0;
      d_valid_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      busy_reg       <= 1'b0;
    end else begin
      // Grants, valids and the write strobe are single-cycle pulses.
      if_gnt_reg   <= 1'b0;
      d_gnt_reg    <= 1'b0;
      if_valid_reg <= 1'b0;
      d_valid_reg  <= 1'b0;
      mem_we_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            state_reg <= ACCESS;
            busy_reg  <= 1'b1;
            if (pick_fetch) begin
              owner_reg      <= 1'b0;
              if_gnt_reg     <= 1'b1;
              mem_addr_reg   <= bus.if_addr;
              mem_wdata_reg  <= '0;
              starve_cnt_reg <= '0;
            end else begin
              owner_reg     <= 1'b1;
              d_gnt_reg     <= 1'b1;
              mem_addr_reg  <= bus.d_addr;
              mem_wdata_reg <= bus.d_wdata;
              mem_we_reg    <= bus.d_we;
              if (bus.if_req && (starve_cnt_reg != SW'(MAX_WAIT))) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          if (MEM_LAT > 1) begin
            state_reg   <= WAIT;
            lat_cnt_reg <= LAT_W'(LAT_LOAD);
          end else begin
            state_reg    <= RESP;
            if_valid_reg <= !owner_reg;
            d_valid_reg  <= owner_reg;
          end
        end
        WAIT: begin
          if (lat_cnt_reg == '0) begin
            state_reg    <= RESP;
            if_valid_reg <= !owner_reg;
            d_valid_reg  <= owner_reg;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt_reg;
  assign bus.d_gnt     = d_gnt_reg;
  assign bus.if_valid  = if_valid_reg;
  assign bus.d_valid   = d_valid_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.busy      = busy_reg;
  // Read data passes straight through; only meaningful alongside the matching valid.
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance A uses MEM_LAT=1, instance B MEM_LAT=3.
// Expected responses are queued when a request is driven and popped when valid appears.
module tb_mem_arbiter;

  typedef struct {
    logic        is_data;
    logic        chk_data;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic preload;
  int   n_checks = 0;
  int   n_err    = 0;
  int   we_cnt_a = 0;
  int   we_cnt_b = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] pipe_a;
  logic [15:0] pipe_b [0:2];

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifb ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .MAX_WAIT(4)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa)
  );
  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .MAX_WAIT(4)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory A: one-cycle read latency.
  always_ff @(posedge clk) begin
    if (preload) begin
      mem_a[16'h0010] <= 16'hA5A5;
    end else if (ifa.mem_we) begin
      mem_a[ifa.mem_addr] <= ifa.mem_wdata;
    end
    pipe_a <= mem_a[ifa.mem_addr];
  end
  assign ifa.mem_rdata = pipe_a;

  // Memory B: three-cycle read latency.
  always_ff @(posedge clk) begin
    if (preload) begin
      mem_b[16'h0300] <= 16'hBEEF;
      mem_b[16'h0040] <= 16'hCAFE;
    end else if (ifb.mem_we) begin
      mem_b[ifb.mem_addr] <= ifb.mem_wdata;
    end
    pipe_b[0] <= mem_b[ifb.mem_addr];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign ifb.mem_rdata = pipe_b[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor A: grant exclusivity, write strobe legality, scoreboard on valid.
  always @(negedge clk) begin
    exp_t e;
    if (ifa.if_gnt || ifa.d_gnt) chk("a_one_gnt", 32'(ifa.if_gnt && ifa.d_gnt), 32'd0);
    if (ifa.mem_we) begin
      we_cnt_a++;
      chk("a_we_in_access", 32'(ifa.d_gnt), 32'd1);
    end
    if (ifa.if_valid || ifa.d_valid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_valid_owner", {30'd0, ifa.d_valid, ifa.if_valid}, {30'd0, e.is_data, !e.is_data});
        if (e.chk_data) chk("a_rdata", 32'(e.is_data ? ifa.d_rdata : ifa.if_rdata), 32'(e.data));
      end
    end
  end

  // Monitor B: same checks for the long-latency instance.
  always @(negedge clk) begin
    exp_t e;
    if (ifb.if_gnt || ifb.d_gnt) chk("b_one_gnt", 32'(ifb.if_gnt && ifb.d_gnt), 32'd0);
    if (ifb.mem_we) begin
      we_cnt_b++;
      chk("b_we_in_access", 32'(ifb.d_gnt), 32'd1);
    end
    if (ifb.if_valid || ifb.d_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_valid_owner", {30'd0, ifb.d_valid, ifb.if_valid}, {30'd0, e.is_data, !e.is_data});
        if (e.chk_data) chk("b_rdata", 32'(e.is_data ? ifb.d_rdata : ifb.if_rdata), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; preload = 1'b1;
    ifa.if_req = 0; ifa.if_addr = 0; ifa.d_req = 0; ifa.d_we = 0; ifa.d_addr = 0; ifa.d_wdata = 0;
    ifb.if_req = 0; ifb.if_addr = 0; ifb.d_req = 0; ifb.d_we = 0; ifb.d_addr = 0; ifb.d_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_gnts", {30'd0, ifa.if_gnt, ifa.d_gnt}, 32'd0);
    chk("rst_valids", {30'd0, ifa.if_valid, ifa.d_valid}, 32'd0);
    chk("rst_mem_we", 32'(ifa.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(ifa.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(ifa.mem_wdata), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; preload = 1'b0;
    $display("reset released");

    // Single fetch, MEM_LAT=1
    ifa.if_req = 1; ifa.if_addr = 16'h0010;
    qa.push_back('{1'b0, 1'b1, 16'hA5A5});
    @(posedge clk); #1;
    chk("f1_if_gnt", 32'(ifa.if_gnt), 32'd1);
    chk("f1_mem_addr", 32'(ifa.mem_addr), 32'h0010);
    chk("f1_busy", 32'(ifa.busy), 32'd1);
    ifa.if_req = 0;
    @(posedge clk); #1;
    chk("f1_if_valid", 32'(ifa.if_valid), 32'd1);
    chk("f1_if_rdata", 32'(ifa.if_rdata), 32'hA5A5);
    @(posedge clk); #1;
    chk("f1_busy_low", 32'(ifa.busy), 32'd0);
    $display("single fetch addr=0010 rdata=%h", ifa.if_rdata);

    // Data write then read back
    ifa.d_req = 1; ifa.d_we = 1; ifa.d_addr = 16'h0200; ifa.d_wdata = 16'h1234;
    qa.push_back('{1'b1, 1'b0, 16'h0000});
    @(posedge clk); #1;
    chk("w_d_gnt", 32'(ifa.d_gnt), 32'd1);
    chk("w_mem_we", 32'(ifa.mem_we), 32'd1);
    chk("w_mem_addr", 32'(ifa.mem_addr), 32'h0200);
    chk("w_mem_wdata", 32'(ifa.mem_wdata), 32'h1234);
    ifa.d_req = 0; ifa.d_we = 0;
    @(posedge clk); #1;
    chk("w_d_valid", 32'(ifa.d_valid), 32'd1);
    chk("w_mem_we_off", 32'(ifa.mem_we), 32'd0);
    @(posedge clk); #1;
    chk("w_we_count", 32'(we_cnt_a), 32'd1);
    $display("data write addr=0200 wdata=1234");
    ifa.d_req = 1; ifa.d_addr = 16'h0200;
    qa.push_back('{1'b1, 1'b1, 16'h1234});
    @(posedge clk); #1;
    chk("r_d_gnt", 32'(ifa.d_gnt), 32'd1);
    ifa.d_req = 0;
    @(posedge clk); #1;
    chk("r_d_valid", 32'(ifa.d_valid), 32'd1);
    @(posedge clk); #1;
    $display("data read addr=0200");

    // Simultaneous requests: data first, fetch at next IDLE
    ifa.if_req = 1; ifa.if_addr = 16'h0010;
    ifa.d_req = 1; ifa.d_addr = 16'h0200;
    qa.push_back('{1'b1, 1'b1, 16'h1234});
    qa.push_back('{1'b0, 1'b1, 16'hA5A5});
    @(posedge clk); #1;
    chk("sim_d_gnt", {30'd0, ifa.d_gnt, ifa.if_gnt}, 32'd2);
    ifa.d_req = 0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    chk("sim_if_gnt", {30'd0, ifa.d_gnt, ifa.if_gnt}, 32'd1);
    ifa.if_req = 0;
    repeat (2) @(posedge clk);
    #1;
    $display("simultaneous requests resolved");

    // Starvation: two rounds of 4 data wins followed by a forced fetch
    for (int r = 0; r < 2; r++) begin
      ifa.if_req = 1; ifa.if_addr = 16'h0010;
      for (int k = 0; k < 5; k++) begin
        ifa.d_req = 1; ifa.d_we = 0; ifa.d_addr = 16'h0200;
        if (k < 4) qa.push_back('{1'b1, 1'b1, 16'h1234});
        else       qa.push_back('{1'b0, 1'b1, 16'hA5A5});
        @(posedge clk); #1;
        if (k < 4) chk("starve_data_wins", {30'd0, ifa.d_gnt, ifa.if_gnt}, 32'd2);
        else       chk("starve_fetch_forced", {30'd0, ifa.d_gnt, ifa.if_gnt}, 32'd1);
        ifa.d_req = 0;
        if (k == 4) ifa.if_req = 0;
        @(posedge clk);
        @(posedge clk); #1;
        $display("starvation round=%0d decision=%0d if_gnt_expected=%0d", r, k, (k == 4));
      end
    end

    // Latency sweep on B (MEM_LAT=3)
    ifb.d_req = 1; ifb.d_we = 0; ifb.d_addr = 16'h0300;
    qb.push_back('{1'b1, 1'b1, 16'hBEEF});
    @(posedge clk); #1;
    chk("lat_d_gnt", 32'(ifb.d_gnt), 32'd1);
    chk("lat_addr_t1", 32'(ifb.mem_addr), 32'h0300);
    ifb.d_req = 0;
    for (int i = 2; i < 4; i++) begin
      @(posedge clk); #1;
      chk("lat_addr_wait", 32'(ifb.mem_addr), 32'h0300);
      chk("lat_no_early_valid", 32'(ifb.d_valid), 32'd0);
      chk("lat_busy", 32'(ifb.busy), 32'd1);
    end
    @(posedge clk); #1;
    chk("lat_d_valid_t4", 32'(ifb.d_valid), 32'd1);
    chk("lat_addr_t4", 32'(ifb.mem_addr), 32'h0300);
    chk("lat_rdata", 32'(ifb.d_rdata), 32'hBEEF);
    @(posedge clk); #1;
    chk("lat_busy_low", 32'(ifb.busy), 32'd0);
    $display("latency sweep read addr=0300 MEM_LAT=3");

    // Reset during WAIT of a data read on B: no response may follow
    ifb.d_req = 1; ifb.d_addr = 16'h0300;
    @(posedge clk); #1;
    chk("rm_d_gnt", 32'(ifb.d_gnt), 32'd1);
    ifb.d_req = 0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("rm_busy", 32'(ifb.busy), 32'd0);
    chk("rm_handshake", {28'd0, ifb.if_gnt, ifb.d_gnt, ifb.if_valid, ifb.d_valid}, 32'd0);
    chk("rm_mem_we", 32'(ifb.mem_we), 32'd0);
    chk("rm_mem_addr", 32'(ifb.mem_addr), 32'd0);
    chk("rm_mem_wdata", 32'(ifb.mem_wdata), 32'd0);
    rst_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    $display("reset mid-access abandoned read");
    ifb.if_req = 1; ifb.if_addr = 16'h0040;
    qb.push_back('{1'b0, 1'b1, 16'hCAFE});
    @(posedge clk); #1;
    chk("rm_if_gnt", 32'(ifb.if_gnt), 32'd1);
    ifb.if_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rm_if_valid", 32'(ifb.if_valid), 32'd1);
    chk("rm_if_rdata", 32'(ifb.if_rdata), 32'hCAFE);
    repeat (3) @(posedge clk);
    #1;
    $display("fetch after reset addr=0040");

    // Every queued response must have been delivered, and write strobes counted exactly
    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    chk("a_total_we", 32'(we_cnt_a), 32'd1);
    chk("b_total_we", 32'(we_cnt_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port of `mem_unit` between two requesters of the 16-bit processor: the instruction-fetch path and the data path used by `lda`/`str`. Each requester sees its own request/grant/valid handshake. The arbiter sequences one access at a time through a fixed-latency synchronous memory. Data accesses have priority, and an anti-starvation counter bounds how long fetch can be held off.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `MEM_LAT`, 1: memory read latency in cycles (≥1); read data is valid `MEM_LAT` cycles after the address is first presented.
- `MAX_WAIT`, 4: consecutive fetch losses before fetch is forced to win (≥1).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch accepted, one-cycle pulse.
- `if_valid` out 1: fetch data valid, one-cycle pulse.
- `if_rdata` out DATA_W: fetch read data.
- `d_req` in 1: data request.
- `d_we` in 1: data write enable.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: data write data.
- `d_gnt` out 1: data accepted, one-cycle pulse.
- `d_valid` out 1: data read data valid, or write acknowledge, one-cycle pulse.
- `d_rdata` out DATA_W: data read data.
- `mem_addr` out ADDR_W: memory address.
- `mem_we` out 1: memory write strobe.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: high in every state except IDLE.

## Operation
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- States: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - A request is sampled when `if_req` or `d_req` is high at a clock edge.
  - The arbiter picks a winner and latches owner, address, `we` and `wdata`, then moves to ACCESS.
  - With no request it stays in IDLE.
- **Priority**
  - Data wins if `d_req` is high, except when both requests are high and `starve_cnt == MAX_WAIT`; then fetch wins.
  - Fetch writes are impossible: the latched `we` is 0 for fetch.
- **Starvation counter** (`starve_cnt`):
  - Increments (saturating at `MAX_WAIT`) on each IDLE decision where both requests are high and data wins.
  - Clears to 0 on every fetch grant.
  - Otherwise holds.
- **ACCESS** lasts exactly 1 cycle.
  - The owner's `*_gnt` is high.
  - `mem_we` equals the latched `we`.
  - `mem_addr` and `mem_wdata` show the latched values.
  - Next state is WAIT if `MEM_LAT > 1`, else RESP.
- **WAIT** lasts `MEM_LAT - 1` cycles, counted down by a latency counter. `mem_addr` is held and `mem_we` is 0.
- **RESP** lasts 1 cycle.
  - The owner's `*_valid` is high and `*_rdata = mem_rdata`.
  - Next state is IDLE.
  - For writes, `d_valid` acts as the write acknowledge and `d_rdata` is don't-care.
- **Requester contract**
  - A requester must drop `req` in the cycle after its `gnt`.
  - Any `req` high in IDLE is a new request.
  - `req` may be withdrawn before it is sampled.
  - Once latched, an access completes even if `req` falls.
- `if_rdata` and `d_rdata` are driven from `mem_rdata`; they are meaningful only while the matching `*_valid` is high.

## Timing
- **Reset values**
  - State is IDLE.
  - `if_gnt`, `d_gnt`, `if_valid`, `d_valid`, `mem_we` and `busy` are 0.
  - `mem_addr` and `mem_wdata` are 0.
  - `starve_cnt` and the latency counter are 0.
- A request sampled at the edge ending IDLE cycle T gives:
  - `gnt` in T+1 (ACCESS);
  - `valid` in T+1+`MEM_LAT` (RESP);
  - the next IDLE decision in T+2+`MEM_LAT`.
- Throughput is one access per `MEM_LAT + 2` cycles.
- `mem_we` is high for exactly one cycle per write and never during WAIT, RESP or IDLE.
- Requests that arrive during ACCESS, WAIT or RESP are ignored until IDLE. They are not queued.
- Simultaneous requests in IDLE are resolved by the priority rules in a single decision.
- Reset asserted in any state:
  - The next state is IDLE and the in-flight access is abandoned.
  - No `valid` is issued for it and no further `mem_we` is driven.
  - Outputs take their reset values in the cycle after the reset edge.
- Outputs are registered except `*_rdata`, which passes `mem_rdata` through.

## Test plan
- **Single fetch**, `MEM_LAT=1`: `if_req` with `if_addr=0x0010` in cycle 0, and `mem_rdata` returns 0xA5A5.
  - `if_gnt` in cycle 1 and `mem_addr=0x0010`.
  - `if_valid` in cycle 2 with `if_rdata=0xA5A5`.
  - `busy` goes low in cycle 3.
- **Data write**: `d_req`, `d_we=1`, `d_addr=0x0200`, `d_wdata=0x1234`.
  - Exactly one `mem_we` cycle, with `mem_addr=0x0200` and `mem_wdata=0x1234`.
  - `d_valid` one cycle later.
  - A following read of 0x0200 returns 0x1234.
- **Simultaneous requests**: `if_req` and `d_req` both high in the same cycle.
  - `d_gnt` first.
  - The fetch is granted at the next IDLE.
  - No cycle has both grants high.
- **Starvation**, `MAX_WAIT=4`: hold `if_req` high and re-raise `d_req` at every IDLE.
  - Data wins 4 times, then fetch is granted on the 5th decision.
  - `starve_cnt` returns to 0 after that grant.
- **Latency sweep**, `MEM_LAT=3`: a single read.
  - `gnt` at T+1 and `valid` at T+4.
  - `mem_addr` is stable from T+1 to T+4.
  - `mem_we=0` throughout.
- **Reset mid-access**: assert `reset` during WAIT of a data read.
  - No `d_valid` is ever issued for that read.
  - All outputs are 0 and `busy=0` the cycle after.
  - A new fetch afterwards completes normally.
